// File: rtl/alu_4bit_arbiter.sv
// Two requesters share one 4-bit add/subtract ALU through a round-robin or
// fixed-priority arbiter. Results return through a one-entry tagged response register.

module alu_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       op_select,
  output logic [3:0] result,
  output logic       carry
);
  logic [3:0] b_eff;
  logic [4:0] sum;

  // SUB is a + ~b + 1, so carry out means "no borrow".
  assign b_eff = op_select ? ~b : b;
  assign sum = {1'b0, a} + {1'b0, b_eff} + {4'b0, op_select};
  assign result = sum[3:0];
  assign carry = sum[4];
endmodule

module alu_4bit_arbiter #(
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic       req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic       req1_op,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [3:0] rsp_result,
  output logic       rsp_carry
);
  logic       last_grant;
  logic       slot_free;
  logic       grant0;
  logic       grant1;
  logic       accept;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic       alu_op;
  logic [3:0] alu_result;
  logic       alu_carry;

  assign slot_free = ~rsp_valid | rsp_ready;

  // On a tie, round-robin favours the requester that did not win last time.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      if (FIXED_PRIORITY || last_grant) grant0 = 1'b1;
      else                              grant1 = 1'b1;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  assign req0_ready = grant0 & slot_free & ~rst;
  assign req1_ready = grant1 & slot_free & ~rst;
  assign accept = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  assign alu_a  = grant1 ? req1_a  : req0_a;
  assign alu_b  = grant1 ? req1_b  : req0_b;
  assign alu_op = grant1 ? req1_op : req0_op;

  alu_4bit u_alu (
    .a         (alu_a),
    .b         (alu_b),
    .op_select (alu_op),
    .result    (alu_result),
    .carry     (alu_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= 4'd0;
      rsp_carry  <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      rsp_valid  <= 1'b1;
      rsp_id     <= grant1;
      rsp_result <= alu_result;
      rsp_carry  <= alu_carry;
      last_grant <= grant1;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule

// File: doc/alu_4bit_arbiter.md
# alu_4bit_arbiter

Shares one `alu_4bit` add/subtract datapath between two independent requesters. Each requester submits an operand pair and an operation over a valid/ready handshake. A round-robin or fixed-priority arbiter grants one request per cycle. The granted operands drive the single ALU instance, and the result is captured in a one-entry output register that returns a tagged response over a valid/ready channel.

## Interface
- `FIXED_PRIORITY`, default 0: 0 selects round-robin arbitration; 1 means requester 0 always wins when both are valid.
- `clk`  input  1  rising-edge clock for all state.
- `rst`  input  1  synchronous, active-high reset.
- `req0_valid`  input  1  requester 0 has a request.
- `req0_ready`  output  1  requester 0's request is accepted this cycle.
- `req0_a`, `req0_b`  input  4 each  requester 0 operands.
- `req0_op`  input  1  requester 0 operation: 0 = ADD, 1 = SUB (a − b).
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_op`: same as requester 0, for requester 1.
- `rsp_valid`  output  1  the response register holds a result.
- `rsp_ready`  input  1  the consumer accepts the response.
- `rsp_id`  output  1  index of the requester that produced the response.
- `rsp_result`  output  4  ALU result.
- `rsp_carry`  output  1  ALU carry out:
  - ADD: overflow out of bit 3.
  - SUB: 1 = no borrow (a ≥ b unsigned).

## Operation
- Exactly one `alu_4bit` instance. Its `a`, `b` and `op_select` inputs are muxed from the granted requester.
- State:
  - Response register: `rsp_valid`, `rsp_id`, `rsp_result`, `rsp_carry`.
  - `last_grant` (1 bit).
- `slot_free = ~rsp_valid | rsp_ready`.
- Grant is computed combinationally each cycle:
  - Only one requester valid: that requester is granted.
  - Both valid, `FIXED_PRIORITY=1`: requester 0 is granted.
  - Both valid, `FIXED_PRIORITY=0`: the requester ≠ `last_grant` is granted.
  - Neither valid: no grant.
- `reqN_ready = grantN & slot_free`. At most one ready is high in any cycle.
- Accept (a valid & ready handshake on requester N) at a rising edge:
  - The response register loads the ALU outputs from requester N's operands.
  - `rsp_id` ← N; `rsp_valid` ← 1; `last_grant` ← N.
- Response drained with no new accept: `rsp_valid` ← 0 and the payload holds its last value.
- No accept: `last_grant` is unchanged.
- Arithmetic is modulo 16, with no saturation:
  - ADD: result = (a + b) mod 16.
  - SUB: result = (a + ~b + 1) mod 16.
- Requester rules:
  - Requester payload must stay stable while `reqN_valid` is high and not yet accepted.
  - The block does not check this rule. A changed payload is simply sampled at the accepting edge.
- Response rules: while `rsp_valid & ~rsp_ready`, all rsp_* outputs hold stable and both readies are 0.
- Combinational paths:
  - `reqN_ready` depends on both valids and on `rsp_ready`.
  - No path exists from any ready back to any valid.

## Timing
- Reset values: `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_carry`=0, `last_grant`=1. The first round-robin tie after reset goes to requester 0.
- Latency: a request accepted at edge N is presented with `rsp_valid`=1 in the cycle after edge N.
- Throughput: one operation per cycle while `rsp_ready` is held at 1. Drain and accept happen on the same edge, so there are no bubbles.
- Back-to-back ties under round-robin alternate 0,1,0,1,…
- Same-edge events:
  - Drain + new accept: the new result replaces the old one and `rsp_valid` stays 1.
  - Drain only: `rsp_valid` falls.
- Reset mid-operation:
  - A buffered, undrained response is discarded: `rsp_valid`=0 after the reset edge.
  - `last_grant` returns to 1.
  - Readies are 0 in any cycle where `rst`=1.
- Requester 1 can starve only when `FIXED_PRIORITY=1`. This is the specified behaviour.

## Test plan
- **Single ADD:** req0 only, a=5, b=3, op=0, `rsp_ready`=1 → next cycle `rsp_valid`=1, `rsp_id`=0, `rsp_result`=8, `rsp_carry`=0.
- **SUB, both carry senses:**
  - req1 a=5, b=3, op=1 → result=2, carry=1.
  - Then req1 a=3, b=5, op=1 → result=14, carry=0, `rsp_id`=1.
- **ADD overflow:** req0 a=15, b=1, op=0 → result=0, carry=1.
- **Round-robin, no bubbles:**
  - Both requesters valid for 6 cycles after reset, `rsp_ready`=1 → `rsp_id` sequence 0,1,0,1,0,1, with `rsp_valid` held at 1 throughout.
  - With `FIXED_PRIORITY=1` → all 0 while req0 stays valid.
- **Backpressure:**
  - Response pending and `rsp_ready`=0 for 3 cycles → rsp_* held constant and both readies 0.
  - `rsp_ready`=1 → drain and new accept on the same edge; the new result appears the next cycle.
- **Reset mid-operation:** `rst`=1 for one cycle while `rsp_valid`=1 → `rsp_valid`=0 and all rsp_* = 0 next cycle. A following tie is granted to requester 0.
